// File: rtl/wsled_serializer.sv
// rtl/wsled_serializer.sv - WS2812-style single-wire serializer for 24-bit GRB pixel words
module wsled_serializer #(
   parameter int BIT_CYCLES   = 62,
   parameter int T0H_CYCLES   = 20,
   parameter int T1H_CYCLES   = 40,
   parameter int LATCH_CYCLES = 14000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] in_data,
   input  logic        in_valid,
   input  logic        in_eop,
   output logic        in_ready,
   output logic        wsled_out,
   output logic        busy,
   output logic        underrun
);

   localparam logic [15:0] BIT_LAST   = 16'(BIT_CYCLES - 1);
   localparam logic [15:0] LATCH_LAST = 16'(LATCH_CYCLES - 1);
   localparam logic [15:0] T0H_LEN    = 16'(T0H_CYCLES);
   localparam logic [15:0] T1H_LEN    = 16'(T1H_CYCLES);

   typedef enum logic [1:0] {IDLE, SEND, WAIT, LATCH} state_t;

   state_t      state_q, state_d;
   logic [23:0] pix_q, pix_d;
   logic        eop_q, eop_d;
   logic [4:0]  bit_idx_q, bit_idx_d;
   logic [15:0] cyc_q, cyc_d;
   logic        wsled_q, wsled_d;
   logic        busy_q, busy_d;
   logic        underrun_q, underrun_d;
   logic        accept;
   logic [15:0] high_len;

   // An eop pixel keeps in_ready low on its last cycle so the latch gap is never skipped.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         case (state_q)
            IDLE:    in_ready = 1'b1;
            WAIT:    in_ready = 1'b1;
            SEND:    in_ready = (bit_idx_q == 5'd0) && (cyc_q == BIT_LAST) && !eop_q;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      pix_d     = pix_q;
      eop_d     = eop_q;
      bit_idx_d = bit_idx_q;
      cyc_d     = cyc_q;
      case (state_q)
         SEND: begin
            if (cyc_q != BIT_LAST) begin
               cyc_d = cyc_q + 16'd1;
            end else if (bit_idx_q != 5'd0) begin
               bit_idx_d = bit_idx_q - 5'd1;
               cyc_d     = 16'd0;
            end else if (!accept) begin
               state_d = eop_q ? LATCH : WAIT;
               cyc_d   = 16'd0;
            end
         end
         WAIT: begin
            if (!accept) begin
               if (cyc_q == LATCH_LAST) begin
                  state_d = IDLE;
                  cyc_d   = 16'd0;
               end else begin
                  cyc_d = cyc_q + 16'd1;
               end
            end
         end
         LATCH: begin
            if (cyc_q == LATCH_LAST) begin
               state_d = IDLE;
               cyc_d   = 16'd0;
            end else begin
               cyc_d = cyc_q + 16'd1;
            end
         end
         default: ;
      endcase
      if (accept) begin
         state_d   = SEND;
         pix_d     = in_data;
         eop_d     = in_eop;
         bit_idx_d = 5'd23;
         cyc_d     = 16'd0;
      end
   end

   // Outputs are computed from the next state so the registered pin lines up with the counters.
   always_comb begin
      high_len   = pix_d[bit_idx_d] ? T1H_LEN : T0H_LEN;
      wsled_d    = (state_d == SEND) && (cyc_d < high_len);
      busy_d     = (state_d != IDLE);
      underrun_d = (state_d == WAIT) && (cyc_d == LATCH_LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pix_q      <= 24'd0;
         eop_q      <= 1'b0;
         bit_idx_q  <= 5'd0;
         cyc_q      <= 16'd0;
         wsled_q    <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         eop_q      <= eop_d;
         bit_idx_q  <= bit_idx_d;
         cyc_q      <= cyc_d;
         wsled_q    <= wsled_d;
         busy_q     <= busy_d;
         underrun_q <= underrun_d;
      end
   end

   assign wsled_out = wsled_q;
   assign busy      = busy_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_wsled_serializer.sv
// tb/tb_wsled_serializer.sv - self-checking bench for wsled_serializer
module tb_wsled_serializer;

   localparam int BIT   = 62;
   localparam int T0H   = 20;
   localparam int T1H   = 40;
   localparam int LATCH = 14000;
   localparam int PIX   = 24 * BIT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] in_data = 24'd0;
   logic        in_valid = 1'b0;
   logic        in_eop = 1'b0;
   logic        in_ready;
   logic        wsled_out;
   logic        busy;
   logic        underrun;

   int n_cmp = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   wsled_serializer dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_eop    (in_eop),
      .in_ready  (in_ready),
      .wsled_out (wsled_out),
      .busy      (busy),
      .underrun  (underrun)
   );

   // Expected pin level k cycles after the first high cycle of pixel p.
   function automatic logic exp_level(input logic [23:0] p, input int k);
      int b;
      int hi;
      b  = 23 - k / BIT;
      hi = p[b] ? T1H : T0H;
      return (k % BIT) < hi;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic abort_with_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0", in_ready); end
      n_cmp++; if ({wsled_out, busy, underrun} !== 3'b000) begin n_err++; $display("FAIL reset_outs got %b exp 000", {wsled_out, busy, underrun}); end
      reset = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
      tick();
      n_cmp++; if ({wsled_out, busy, underrun, in_ready} !== 4'b0001) begin n_err++; $display("FAIL idle_outs got %b exp 0001", {wsled_out, busy, underrun, in_ready}); end
   endtask

   task automatic test_single_pixel();
      logic [23:0] p;
      p = 24'h800001;
      in_data = p; in_eop = 1'b1; in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_accept_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0; in_data = 24'($urandom); in_eop = 1'($urandom);
      for (int k = 0; k < PIX; k++) begin
         n_cmp++;
         if ({wsled_out, busy, in_ready, underrun} !== {exp_level(p, k), 3'b100}) begin
            n_err++;
            $display("FAIL single_wave k=%0d got %b exp %b", k, {wsled_out, busy, in_ready, underrun}, {exp_level(p, k), 3'b100});
         end
         tick();
      end
      in_valid = 1'b1; in_data = 24'($urandom); in_eop = 1'b1;
      for (int j = 0; j < LATCH; j++) begin
         n_cmp++;
         if ({wsled_out, busy, in_ready, underrun} !== 4'b0100) begin
            n_err++;
            $display("FAIL single_latch j=%0d got %b exp 0100", j, {wsled_out, busy, in_ready, underrun});
         end
         tick();
      end
      in_valid = 1'b0;
      n_cmp++; if ({busy, in_ready} !== 2'b01) begin n_err++; $display("FAIL single_latch_end got %b exp 01", {busy, in_ready}); end
      tick();
   endtask

   task automatic test_back_to_back(input logic [23:0] p1, input logic [23:0] p2, input logic [23:0] p3);
      logic [23:0] p;
      in_data = p1; in_eop = 1'b0; in_valid = 1'b1;
      tick();
      in_data = p2; in_eop = 1'b1;
      for (int k = 0; k < 2 * PIX; k++) begin
         p = (k < PIX) ? p1 : p2;
         n_cmp++;
         if ({wsled_out, busy, in_ready, underrun} !== {exp_level(p, k % PIX), 1'b1, (k == PIX - 1), 1'b0}) begin
            n_err++;
            $display("FAIL b2b_wave k=%0d got %b exp %b", k, {wsled_out, busy, in_ready, underrun}, {exp_level(p, k % PIX), 1'b1, (k == PIX - 1), 1'b0});
         end
         tick();
         if (k == PIX - 1) begin
            in_data = p3; in_eop = 1'b1;
         end
      end
      for (int j = 0; j < LATCH; j++) begin
         n_cmp++;
         if ({wsled_out, busy, in_ready} !== 3'b010) begin
            n_err++;
            $display("FAIL backpressure_latch j=%0d got %b exp 010", j, {wsled_out, busy, in_ready});
         end
         tick();
      end
      n_cmp++; if ({busy, in_ready} !== 2'b01) begin n_err++; $display("FAIL backpressure_idle got %b exp 01", {busy, in_ready}); end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 2 * BIT; k++) begin
         n_cmp++;
         if ({wsled_out, busy} !== {exp_level(p3, k), 1'b1}) begin
            n_err++;
            $display("FAIL backpressure_wave k=%0d got %b exp %b", k, {wsled_out, busy}, {exp_level(p3, k), 1'b1});
         end
         tick();
      end
      abort_with_reset();
   endtask

   task automatic test_underrun();
      logic [23:0] p;
      p = 24'h123456;
      in_data = p; in_eop = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < PIX; k++) begin
         n_cmp++;
         if ({wsled_out, underrun} !== {exp_level(p, k), 1'b0}) begin
            n_err++;
            $display("FAIL underrun_wave k=%0d got %b exp %b", k, {wsled_out, underrun}, {exp_level(p, k), 1'b0});
         end
         tick();
      end
      for (int j = 0; j < LATCH; j++) begin
         n_cmp++;
         if ({wsled_out, busy, in_ready, underrun} !== {3'b011, (j == LATCH - 1)}) begin
            n_err++;
            $display("FAIL underrun_wait j=%0d got %b exp %b", j, {wsled_out, busy, in_ready, underrun}, {3'b011, (j == LATCH - 1)});
         end
         tick();
      end
      n_cmp++; if ({wsled_out, busy, in_ready, underrun} !== 4'b0010) begin n_err++; $display("FAIL underrun_after got %b exp 0010", {wsled_out, busy, in_ready, underrun}); end
      tick();
   endtask

   task automatic test_late_resume();
      logic [23:0] p1;
      logic [23:0] p2;
      p1 = 24'($urandom); p2 = 24'($urandom);
      in_data = p1; in_eop = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < PIX; k++) begin
         n_cmp++;
         if (wsled_out !== exp_level(p1, k)) begin n_err++; $display("FAIL resume_wave1 k=%0d got %b exp %b", k, wsled_out, exp_level(p1, k)); end
         tick();
      end
      for (int j = 0; j < 1000; j++) begin
         n_cmp++;
         if ({wsled_out, busy, in_ready, underrun} !== 4'b0110) begin
            n_err++;
            $display("FAIL resume_wait j=%0d got %b exp 0110", j, {wsled_out, busy, in_ready, underrun});
         end
         tick();
      end
      in_data = p2; in_eop = 1'b1; in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL resume_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < PIX; k++) begin
         n_cmp++;
         if ({wsled_out, underrun} !== {exp_level(p2, k), 1'b0}) begin
            n_err++;
            $display("FAIL resume_wave2 k=%0d got %b exp %b", k, {wsled_out, underrun}, {exp_level(p2, k), 1'b0});
         end
         tick();
      end
      n_cmp++; if ({wsled_out, busy, in_ready} !== 3'b010) begin n_err++; $display("FAIL resume_latch got %b exp 010", {wsled_out, busy, in_ready}); end
      abort_with_reset();
   endtask

   task automatic test_reset_mid_bit();
      logic [23:0] p;
      logic [23:0] p2;
      p = 24'($urandom) | 24'h800000;
      p2 = 24'($urandom);
      in_data = p; in_eop = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         n_cmp++;
         if (wsled_out !== exp_level(p, k)) begin n_err++; $display("FAIL midbit_wave k=%0d got %b exp %b", k, wsled_out, exp_level(p, k)); end
         if (k < 10) tick();
      end
      reset = 1'b1;
      #1;
      n_cmp++; if ({wsled_out, busy, in_ready, underrun} !== 4'b0000) begin n_err++; $display("FAIL midbit_async got %b exp 0000", {wsled_out, busy, in_ready, underrun}); end
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if ({wsled_out, busy, in_ready, underrun} !== 4'b0010) begin n_err++; $display("FAIL midbit_release got %b exp 0010", {wsled_out, busy, in_ready, underrun}); end
      in_data = p2; in_eop = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < PIX; k++) begin
         n_cmp++;
         if ({wsled_out, busy, underrun} !== {exp_level(p2, k), 2'b10}) begin
            n_err++;
            $display("FAIL midbit_new_wave k=%0d got %b exp %b", k, {wsled_out, busy, underrun}, {exp_level(p2, k), 2'b10});
         end
         tick();
      end
      abort_with_reset();
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_back_to_back(24'hFFFFFF, 24'h000000, 24'($urandom));
      test_underrun();
      test_late_resume();
      test_reset_mid_bit();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
